// File: rtl/cwalk_head.sv
// cwalk_head: pedestrian crosswalk head driver (lamps, countdown digit, fault latch).
// Optional walk chirp is built when CWALK_HEAD_CHIRP_EN is defined.
`default_nettype none

module cwalk_head #(
    parameter int FLASH_DIV = 4,
    parameter int CHIRP_DIV = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       i_walk,
    input  logic       i_hand,
    input  logic       i_num_on,
    input  logic [3:0] i_num,
    output logic       o_walk_lamp,
    output logic       o_hand_lamp,
    output logic [6:0] o_seg,
    output logic       o_seg_en,
    output logic       o_fault,
    output logic       o_chirp
);

    localparam logic [2:0] c_DARK     = 3'd0;
    localparam logic [2:0] c_WALK     = 3'd1;
    localparam logic [2:0] c_CLEAR    = 3'd2;
    localparam logic [2:0] c_DONTWALK = 3'd3;
    localparam logic [2:0] c_FAULT    = 3'd4;

    localparam int FW = $clog2(2 * FLASH_DIV + 1);
    localparam logic [FW-1:0] c_FLASH_LAST = FW'(2 * FLASH_DIV - 1);
    localparam logic [FW-1:0] c_FLASH_HALF = FW'(FLASH_DIV);

    logic       r_walk, r_hand, r_num_on;
    logic [3:0] r_num, r_last_num;
    logic [2:0] r_state, w_state_nxt;
    logic [FW-1:0] r_flash, w_flash_nxt;
    logic       w_bad;
    logic       r_walk_lamp, r_hand_lamp, r_seg_en, r_fault;
    logic [6:0] r_seg;

    function automatic logic [6:0] f_seg(input logic [3:0] n);
        case (n)
            4'd0:    f_seg = 7'h7E;
            4'd1:    f_seg = 7'h30;
            4'd2:    f_seg = 7'h6D;
            4'd3:    f_seg = 7'h79;
            4'd4:    f_seg = 7'h33;
            4'd5:    f_seg = 7'h5B;
            4'd6:    f_seg = 7'h5F;
            4'd7:    f_seg = 7'h70;
            4'd8:    f_seg = 7'h7F;
            4'd9:    f_seg = 7'h7B;
            default: f_seg = 7'h00;
        endcase
    endfunction

    assign w_bad = (r_walk & r_hand) |
                   (r_num_on & (r_walk | ~r_hand | (r_num > 4'd9)));

    always_comb begin
        w_state_nxt = r_state;
        if (r_state != c_FAULT) begin
            if (w_bad) begin
                w_state_nxt = c_FAULT;
            end else if (r_num_on) begin
                // Staying in CLEAR the count may only hold or step down by one.
                if ((r_state == c_CLEAR) && (r_num != r_last_num) &&
                    (r_num != (r_last_num - 4'd1))) begin
                    w_state_nxt = c_FAULT;
                end else begin
                    w_state_nxt = c_CLEAR;
                end
            end else if (r_walk) begin
                w_state_nxt = c_WALK;
            end else if (r_hand) begin
                w_state_nxt = c_DONTWALK;
            end else begin
                w_state_nxt = c_DARK;
            end
        end
    end

    assign w_flash_nxt = ((r_state != c_CLEAR) || (r_flash == c_FLASH_LAST)) ?
                         '0 : r_flash + 1'b1;

    // Outputs are registered from the next state so the response lands two edges after an input change.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_walk      <= 1'b0;
            r_hand      <= 1'b0;
            r_num_on    <= 1'b0;
            r_num       <= 4'd0;
            r_last_num  <= 4'd0;
            r_state     <= c_DARK;
            r_flash     <= '0;
            r_walk_lamp <= 1'b0;
            r_hand_lamp <= 1'b0;
            r_seg       <= 7'd0;
            r_seg_en    <= 1'b0;
            r_fault     <= 1'b0;
        end else begin
            r_walk      <= i_walk;
            r_hand      <= i_hand;
            r_num_on    <= i_num_on;
            r_num       <= i_num;
            r_state     <= w_state_nxt;
            r_last_num  <= (w_state_nxt == c_CLEAR) ? r_num : r_last_num;
            r_flash     <= (w_state_nxt == c_CLEAR) ? w_flash_nxt : '0;
            r_walk_lamp <= (w_state_nxt == c_WALK);
            r_hand_lamp <= (w_state_nxt == c_DONTWALK) || (w_state_nxt == c_FAULT) ||
                           ((w_state_nxt == c_CLEAR) && (w_flash_nxt < c_FLASH_HALF));
            r_seg       <= (w_state_nxt == c_CLEAR) ? f_seg(r_num) : 7'd0;
            r_seg_en    <= (w_state_nxt == c_CLEAR);
            r_fault     <= (w_state_nxt == c_FAULT);
        end
    end

`ifdef CWALK_HEAD_CHIRP_EN
    localparam int CW = $clog2(CHIRP_DIV + 1);
    localparam logic [CW-1:0] c_CHIRP_LAST = CW'(CHIRP_DIV - 1);

    logic [CW-1:0] r_chirp_cnt, w_chirp_nxt;
    logic          r_chirp;

    assign w_chirp_nxt = ((r_state != c_WALK) || (r_chirp_cnt == c_CHIRP_LAST)) ?
                         '0 : r_chirp_cnt + 1'b1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_chirp_cnt <= '0;
            r_chirp     <= 1'b0;
        end else begin
            r_chirp_cnt <= (w_state_nxt == c_WALK) ? w_chirp_nxt : '0;
            r_chirp     <= (w_state_nxt == c_WALK) && (r_state == c_WALK) &&
                           (w_chirp_nxt == '0);
        end
    end

    assign o_chirp = r_chirp;
`else
    // Always false; keeps CHIRP_DIV referenced when the chirp is not built.
    assign o_chirp = (CHIRP_DIV < 0);
`endif

    assign o_walk_lamp = r_walk_lamp;
    assign o_hand_lamp = r_hand_lamp;
    assign o_seg       = r_seg;
    assign o_seg_en    = r_seg_en;
    assign o_fault     = r_fault;

endmodule

`default_nettype wire

// File: tb/tb_cwalk_head.sv
// tb_cwalk_head: directed self-checking bench for cwalk_head.
`default_nettype none

module tb_cwalk_head;

    logic       clk = 1'b1;
    logic       reset;
    logic       walk, hand, num_on;
    logic [3:0] num;
    logic       walk_lamp, hand_lamp, seg_en, fault, chirp;
    logic [6:0] seg;

    int n_tests = 0;
    int n_fail  = 0;

    logic [6:0] seg_tab [0:9] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33,
                                  7'h5B, 7'h5F, 7'h70, 7'h7F, 7'h7B};

    cwalk_head #(.FLASH_DIV(4), .CHIRP_DIV(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .i_walk     (walk),
        .i_hand     (hand),
        .i_num_on   (num_on),
        .i_num      (num),
        .o_walk_lamp(walk_lamp),
        .o_hand_lamp(hand_lamp),
        .o_seg      (seg),
        .o_seg_en   (seg_en),
        .o_fault    (fault),
        .o_chirp    (chirp)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // {walk_lamp, hand_lamp, seg, seg_en, fault, chirp}
    function automatic logic [15:0] outs();
        return {5'd0, walk_lamp, hand_lamp, seg, seg_en, fault, chirp};
    endfunction

    initial begin
        reset = 1'b0; walk = 1'b0; hand = 1'b0; num_on = 1'b0; num = 4'd0;
        #50;
        chk("reset_outs", outs(), 16'd0);
        #55;
        reset = 1'b1;
        step(1);
        chk("dark_outs", outs(), 16'd0);

        walk = 1'b1;
        step(1);
        chk("walk_latency1", {15'd0, walk_lamp}, 16'd0);
        step(1);
        chk("walk_lamp", {15'd0, walk_lamp}, 16'd1);
        chk("walk_seg_en", {15'd0, seg_en}, 16'd0);
        chk("walk_hand", {15'd0, hand_lamp}, 16'd0);

        for (int k = 0; k < 20; k++) begin
`ifdef CWALK_HEAD_CHIRP_EN
            chk($sformatf("chirp_k%0d", k), {15'd0, chirp}, {15'd0, (k == 8) || (k == 16)});
`else
            chk($sformatf("chirp_off_k%0d", k), {15'd0, chirp}, 16'd0);
`endif
            step(1);
        end

        walk = 1'b0; hand = 1'b1; num_on = 1'b1; num = 4'd9;
        step(2);
        for (int d = 9; d >= 0; d--) begin
            for (int i = 0; i < 8; i++) begin
                int j;
                j = (9 - d) * 8 + i;
                chk($sformatf("clr_seg_d%0d_i%0d", d, i), {9'd0, seg}, {9'd0, seg_tab[d]});
                chk($sformatf("clr_hand_j%0d", j), {15'd0, hand_lamp}, {15'd0, (j % 8) < 4});
                chk($sformatf("clr_flags_j%0d", j), {13'd0, seg_en, fault, walk_lamp}, 16'b100);
                if (i == 6 && d > 0) num = 4'(d - 1);
                step(1);
            end
        end

        num_on = 1'b0;
        step(2);
        chk("dontwalk_outs", outs(), {5'd0, 1'b0, 1'b1, 7'd0, 1'b0, 1'b0, 1'b0});
        num_on = 1'b1; num = 4'd5;
        step(2);
        chk("reentry_seg5", {9'd0, seg}, 16'h5B);
        chk("reentry_hand", {14'd0, hand_lamp, fault}, 16'b10);
        num = 4'd7;
        step(1);
        chk("jump_latency1", {15'd0, fault}, 16'd0);
        step(1);
        chk("jump_fault", outs(), {5'd0, 1'b0, 1'b1, 7'd0, 1'b0, 1'b1, 1'b0});
        walk = 1'b1; hand = 1'b0; num_on = 1'b0;
        for (int k = 0; k < 6; k++) begin
            step(1);
            chk($sformatf("fault_sticky_%0d", k), outs(), {5'd0, 1'b0, 1'b1, 7'd0, 1'b0, 1'b1, 1'b0});
        end

        #2 reset = 1'b0;
        #1 chk("async_reset_from_fault", outs(), 16'd0);
        walk = 1'b1; hand = 1'b1;
        @(negedge clk) reset = 1'b1;
        step(1);
        chk("both_latency1", {15'd0, fault}, 16'd0);
        step(1);
        chk("both_fault", {14'd0, fault, hand_lamp}, 16'b11);
        hand = 1'b0;
        step(3);
        chk("fault_after_walk", {14'd0, fault, walk_lamp}, 16'b10);
        #2 reset = 1'b0;
        #1 chk("reset_pulse_outs", outs(), 16'd0);

        walk = 1'b0; hand = 1'b1; num_on = 1'b1; num = 4'd12;
        @(negedge clk) reset = 1'b1;
        step(2);
        chk("num12_fault", {14'd0, fault, seg_en}, 16'b10);
        chk("num12_seg", {9'd0, seg}, 16'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/cwalk_head.md
CWALK_HEAD -- requirements
Module: cwalk_head

Interface
REQ-001 Parameters SHALL be as follows.
  - FLASH_DIV, default 4: half-period of the flashing hand, in clk cycles.
  - CHIRP_DIV, default 8: period of the walk chirp pulse, in clk cycles.
REQ-002 clk  input  1  single system clock; all state changes on its rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset (0 = in reset).
REQ-004 walk  input  1  walk indication from the crosswalk controller.
REQ-005 hand  input  1  hand (don't-walk) indication from the crosswalk controller.
REQ-006 num_on  input  1  countdown-valid flag from the controller.
REQ-007 num  input  4  countdown value; meaningful only when num_on=1.
REQ-008 walk_lamp  output  1  walking-figure lamp drive, active high.
REQ-009 hand_lamp  output  1  hand lamp drive, active high.
REQ-010 seg  output  7  segment drive, seg[6]=a .. seg[0]=g, active high.
REQ-011 seg_en  output  1  digit enable for seg.
REQ-012 fault  output  1  sticky protocol-violation flag.
REQ-013 chirp  output  1  audible chirp pulse; see Configuration.

Function
REQ-014 Inputs SHALL be registered once; the FSM SHALL act on the registered copies; all outputs SHALL be registered.
  - Latency from an input change to the output response is exactly 2 clk cycles.
REQ-015 The FSM SHALL have states DARK, WALK, CLEAR, DONTWALK and FAULT.
REQ-016 Decode from any non-FAULT state SHALL be:
  - walk=1, hand=0, num_on=0 -> WALK.
  - hand=1, walk=0, num_on=1 -> CLEAR.
  - hand=1, walk=0, num_on=0 -> DONTWALK.
  - walk=0, hand=0, num_on=0 -> DARK.
REQ-017 The following SHALL cause a transition to FAULT:
  - walk=1 and hand=1 together;
  - num_on=1 with walk=1;
  - num_on=1 with hand=0;
  - num_on=1 with num>9.
REQ-018 While in CLEAR and remaining in CLEAR, a new num SHALL equal the previous num or previous num-1.
  - Any other value -> FAULT, including an increase and a wrap from 0 to 15.
  - The first num on entering CLEAR may be any value 0..9.
REQ-019 FAULT SHALL be terminal until reset.
  - Outputs in FAULT: walk_lamp=0, hand_lamp=1 steady, seg=0, seg_en=0, fault=1.
REQ-020 Lamp outputs SHALL be:
  - WALK: walk_lamp=1, hand_lamp=0.
  - DONTWALK: hand_lamp=1 steady, walk_lamp=0.
  - DARK: both lamps 0.
REQ-021 In CLEAR, hand_lamp SHALL flash.
  - A phase counter clears on CLEAR entry.
  - hand_lamp=1 for the first FLASH_DIV cycles, then 0 for FLASH_DIV cycles, repeating.
  - walk_lamp=0.
REQ-022 In CLEAR, seg_en SHALL be 1 and seg SHALL show num.
  - Encoding: 0=7E, 1=30, 2=6D, 3=79, 4=33, 5=5B, 6=5F, 7=70, 8=7F, 9=7B (hex).
  - In every other state: seg=0, seg_en=0.
REQ-023 A CLEAR->CLEAR update with a legal num SHALL NOT restart the flash phase.

Reset
REQ-024 While reset=0, all of the following SHALL hold immediately, independent of clk:
  - state=DARK;
  - input registers, flash and chirp counters = 0;
  - walk_lamp, hand_lamp, seg, seg_en, fault, chirp = 0.
REQ-025 Reset asserted mid-CLEAR or in FAULT SHALL clear everything, including fault.
  - The first input decode after release occurs on the second rising clk edge.

Configuration
REQ-026 Macro CWALK_HEAD_CHIRP_EN SHALL control the chirp feature.
  - Defined: in WALK, chirp=1 for one cycle every CHIRP_DIV cycles.
  - The first pulse occurs CHIRP_DIV cycles after WALK entry.
  - The counter clears on leaving WALK, and chirp=0 in all other states.
  - Undefined: chirp is tied to 0 and no chirp counter is synthesised.

Verification
REQ-027 The bench SHALL cover these directed scenarios:
  - Reset 0 for 105 ns, then walk=1 -> walk_lamp=1 two cycles later; seg_en=0.
  - hand=1, num_on=1, num stepping 9,8,..,0, each held 8 cycles, FLASH_DIV=4 -> seg=7B..7E in sequence; hand_lamp toggles every 4 cycles; fault=0.
  - In CLEAR, num 5 then 7 -> fault=1 two cycles later; hand_lamp steady 1; stays set until reset=0.
  - walk=1 and hand=1 together -> fault=1; then walk=1, hand=0 -> still FAULT; reset pulse -> all outputs 0.
  - num_on=1, num=12 with hand=1 -> fault=1, seg_en=0.
  - CWALK_HEAD_CHIRP_EN defined, WALK held 20 cycles, CHIRP_DIV=8 -> chirp pulses at cycles 8 and 16 after WALK entry; macro undefined -> chirp always 0.
